// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, frame-format encodings and helpers
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } rx_state_t;

    localparam logic PARITY_EVEN = 1'b1;
    localparam logic PARITY_ODD  = 1'b0;

    localparam logic [1:0] DB5 = 2'b00;
    localparam logic [1:0] DB6 = 2'b01;
    localparam logic [1:0] DB7 = 2'b10;
    localparam logic [1:0] DB8 = 2'b11;

    function automatic logic [3:0] data_bits(input logic [1:0] data_bit_num);
        return 4'd5 + {2'b00, data_bit_num};
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver config inputs and parallel result bundle
interface uart_rx_if;
    logic [1:0] data_bit_num;
    logic       stop_bit_num;
    logic       parity_en;
    logic       parity_type;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        input  data_bit_num, stop_bit_num, parity_en, parity_type,
        output rx_data, rx_valid, parity_err, frame_err, rx_busy
    );

    modport slave (
        output data_bit_num, stop_bit_num, parity_en, parity_type,
        input  rx_data, rx_valid, parity_err, frame_err, rx_busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the async rx line plus falling-edge detect
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx_in,
    output logic rx_s,
    output logic fall
);

    logic s1;
    logic s2;
    logic prev;

    // Flops reset to the idle-high line level so reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            prev <= 1'b1;
        end else begin
            s1   <= rx_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rx_s = s2;
    assign fall = prev & ~s2;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: baud timing, frame FSM and parallel result strobe
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx,
    uart_rx_if.master    bus
);

    localparam int CW = (BAUD_DIV < 1) ? 1 : $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV);
    localparam logic [CW-1:0] CNT_MID  = CW'(BAUD_DIV / 2);

    logic          rx_s;
    logic          fall;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [2:0]    last_idx;
    logic [7:0]    shreg;
    logic          cfg_two_stop;
    logic          cfg_parity_en;
    logic          cfg_parity_type;
    logic          perr_acc;
    logic          ferr_acc;
    logic          done;
    logic          samp;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rx_in (rx),
        .rx_s  (rx_s),
        .fall  (fall)
    );

    assign samp = (state == ST_START) ? (cnt == CNT_MID) : (cnt == CNT_FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            idx             <= 3'd0;
            last_idx        <= 3'd0;
            shreg           <= 8'h00;
            cfg_two_stop    <= 1'b0;
            cfg_parity_en   <= 1'b0;
            cfg_parity_type <= 1'b0;
            perr_acc        <= 1'b0;
            ferr_acc        <= 1'b0;
            done            <= 1'b0;
            bus.rx_data     <= 8'h00;
            bus.rx_valid    <= 1'b0;
            bus.parity_err  <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.rx_busy     <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            done         <= 1'b0;
            // Publish one cycle after the FSM finished so the accumulators have settled.
            if (done) begin
                bus.rx_valid   <= 1'b1;
                bus.rx_data    <= shreg;
                bus.parity_err <= perr_acc;
                bus.frame_err  <= ferr_acc;
            end
            if (state != ST_IDLE) begin
                cnt <= samp ? '0 : cnt + 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state           <= ST_START;
                        cnt             <= '0;
                        idx             <= 3'd0;
                        last_idx        <= 3'(data_bits(bus.data_bit_num) - 4'd1);
                        cfg_two_stop    <= bus.stop_bit_num;
                        cfg_parity_en   <= bus.parity_en;
                        cfg_parity_type <= bus.parity_type;
                        shreg           <= 8'h00;
                        perr_acc        <= 1'b0;
                        ferr_acc        <= 1'b0;
                        bus.rx_busy     <= 1'b1;
                    end
                end
                ST_START: begin
                    if (samp) begin
                        if (rx_s) begin
                            state       <= ST_IDLE;
                            bus.rx_busy <= 1'b0;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (samp) begin
                        shreg[idx] <= rx_s;
                        if (idx == last_idx) begin
                            state <= cfg_parity_en ? ST_PARITY : ST_STOP1;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (samp) begin
                        // Bits above the frame width are zero, so a full-word reduction is exact.
                        perr_acc <= rx_s != ((cfg_parity_type == PARITY_EVEN) ? ^shreg : ~^shreg);
                        state    <= ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    if (samp) begin
                        if (!rx_s) begin
                            ferr_acc <= 1'b1;
                        end
                        if (cfg_two_stop) begin
                            state <= ST_STOP2;
                        end else begin
                            state       <= ST_IDLE;
                            bus.rx_busy <= 1'b0;
                            done        <= 1'b1;
                        end
                    end
                end
                ST_STOP2: begin
                    if (samp) begin
                        if (!rx_s) begin
                            ferr_acc <= 1'b1;
                        end
                        state       <= ST_IDLE;
                        bus.rx_busy <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    bus.rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx against a frame-level reference model
module tb_uart_rx;

    localparam int BAUD_DIV = 15;
    localparam int BIT      = BAUD_DIV + 1;
    localparam int MID      = BAUD_DIV / 2;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    int   cyc = 0;
    logic rst_q = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   strobes = 0;
    exp_t q[$];
    logic [7:0] held_data = 8'h00;
    logic       held_perr = 1'b0;
    logic       held_ferr = 1'b0;

    uart_rx_if bus ();

    uart_rx #(.BAUD_DIV(BAUD_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of the DUT outputs with the model's view of the link.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst_q) begin
                q.delete();
                held_data = 8'h00;
                held_perr = 1'b0;
                held_ferr = 1'b0;
                chk("reset_valid", bus.rx_valid, 0);
                chk("reset_busy", bus.rx_busy, 0);
                chk("reset_data", bus.rx_data, 0);
                chk("reset_errs", {bus.parity_err, bus.frame_err}, 0);
            end else if (bus.rx_valid) begin
                strobes++;
                if (q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("rx_data", bus.rx_data, e.data);
                    chk("parity_err", bus.parity_err, e.perr);
                    chk("frame_err", bus.frame_err, e.ferr);
                    chk("busy_at_valid", bus.rx_busy, 0);
                    held_data = e.data;
                    held_perr = e.perr;
                    held_ferr = e.ferr;
                end
            end else begin
                chk("hold", {bus.rx_data, bus.parity_err, bus.frame_err},
                    {held_data, held_perr, held_ferr});
                if (q.size() > 0 && cyc > q[0].cyc) begin
                    chk("missed_strobe", cyc, q[0].cyc);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at #1 after a rising edge; the start bit is driven immediately.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] dbn, input logic sb,
                              input logic pe, input logic pt, input logic pflip,
                              input logic st1, input logic st2, input int abort_bit);
        int n;
        int nb;
        int s;
        logic [7:0] dm;
        logic [11:0] fr;
        exp_t e;
        n  = 5 + int'(dbn);
        dm = d & (8'hFF >> (8 - n));
        fr = '0;
        nb = 1;
        for (int i = 0; i < n; i++) begin
            fr[nb] = dm[i];
            nb++;
        end
        if (pe) begin
            fr[nb] = (pt ? ^dm : ~^dm) ^ pflip;
            nb++;
        end
        fr[nb] = st1;
        nb++;
        if (sb) begin
            fr[nb] = st2;
            nb++;
        end
        bus.data_bit_num = dbn;
        bus.stop_bit_num = sb;
        bus.parity_en    = pe;
        bus.parity_type  = pt;
        s = cyc;
        if (abort_bit < 0) begin
            e.data = dm;
            e.perr = pe & pflip;
            e.ferr = ~st1 | (sb & ~st2);
            e.cyc  = s + 5 + MID + BIT * (nb - 1);
            q.push_back(e);
        end
        for (int i = 0; i < nb; i++) begin
            if (i == 1) begin
                {bus.data_bit_num, bus.stop_bit_num, bus.parity_en, bus.parity_type} = 5'($urandom);
            end
            rx = fr[i];
            for (int j = 0; j < BIT; j++) begin
                if (i == abort_bit && j == 8) begin
                    reset = 1'b1;
                    @(posedge clk);
                    #1;
                    reset = 1'b0;
                    idle(40);
                    return;
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        bus.data_bit_num = DB8_C();
        bus.stop_bit_num = 1'b0;
        bus.parity_en    = 1'b0;
        bus.parity_type  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(5);
        chk("post_reset_busy", bus.rx_busy, 0);

        send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle(10);
        chk("a5_data", bus.rx_data, 8'hA5);
        chk("a5_errs", {bus.parity_err, bus.frame_err}, 2'b00);
        chk("a5_busy", bus.rx_busy, 0);

        send_frame(8'h13, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        idle(10);
        chk("5e1_data", bus.rx_data, 8'h13);
        chk("5e1_perr_ok", bus.parity_err, 0);
        send_frame(8'h13, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, -1);
        idle(10);
        chk("5e1_perr_bad", bus.parity_err, 1);

        send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(10);
        chk("3c_data", bus.rx_data, 8'h3C);
        chk("3c_ferr", bus.frame_err, 1);

        send_frame(8'h81, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        idle(10);
        chk("8o2_ferr_stop2", bus.frame_err, 1);
        send_frame(8'h81, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle(10);
        chk("8o2_ferr_clean", {bus.rx_data, bus.parity_err, bus.frame_err}, {8'h81, 2'b00});

        begin
            int s;
            logic saw;
            saw = 1'b0;
            s = cyc;
            rx = 1'b0;
            repeat (4) begin
                @(posedge clk);
                #1;
            end
            rx = 1'b1;
            while (cyc < s + 11) begin
                @(negedge clk);
                if (bus.rx_busy) saw = 1'b1;
            end
            chk("glitch_busy_seen", saw, 1);
            chk("glitch_busy_clear", bus.rx_busy, 0);
            @(posedge clk);
            #1;
            idle(20);
        end

        send_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        chk("abort_data", bus.rx_data, 0);
        chk("abort_busy", bus.rx_busy, 0);
        send_frame(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        idle(10);
        chk("c3_data", bus.rx_data, 8'hC3);

        begin
            int base;
            base = strobes;
            send_frame(8'h01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
            chk("b2b_first", bus.rx_data, 8'h01);
            send_frame(8'hFE, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
            chk("b2b_second", bus.rx_data, 8'hFE);
            chk("b2b_count", strobes - base, 2);
        end

        begin
            exp_t e;
            bus.data_bit_num = 2'b11;
            bus.stop_bit_num = 1'b0;
            bus.parity_en    = 1'b0;
            e.data = 8'h00;
            e.perr = 1'b0;
            e.ferr = 1'b1;
            e.cyc  = cyc + 5 + MID + BIT * 9;
            q.push_back(e);
            rx = 1'b0;
            repeat (BIT * 20) begin
                @(posedge clk);
                #1;
            end
            chk("break_data", bus.rx_data, 0);
            chk("break_ferr", bus.frame_err, 1);
            chk("break_no_retrigger", bus.rx_busy, 0);
            idle(20);
        end

        for (int k = 0; k < 40; k++) begin
            logic sb;
            logic st1;
            logic st2;
            int gap;
            sb  = 1'($urandom);
            st1 = ($urandom_range(0, 5) != 0);
            st2 = ($urandom_range(0, 5) != 0);
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20);
            if ((sb ? st2 : st1) == 1'b0 && gap == 0) gap = 1;
            send_frame(8'($urandom), 2'($urandom), sb, 1'($urandom), 1'($urandom),
                       1'($urandom), st1, st2, -1);
            if (gap > 0) idle(gap);
        end

        for (int t = 0; t < 500 && q.size() > 0; t++) begin
            @(posedge clk);
        end
        #1;
        chk("drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic [1:0] DB8_C();
        return 2'b11;
    endfunction

endmodule
